pixel_write_buffer: RTL and testbench
=====================================

// Module: pixel_write_buffer
// PURPOSE
//  Downstream of the chunk drawer. Accepts its free-running pixel stream (x, y, r, g, b, valid)
//  and bounds-checks each pixel. Converts coordinates to a linear framebuffer address and buffers
//  writes in a FIFO. Presents them to the framebuffer write port with a valid/ready handshake.
//  Absorbs framebuffer stalls; the drawer never waits.
// PARAMETERS
//  DEPTH   8    FIFO entries; power of 2, >= 2
//  H_RES   640  visible columns; x >= H_RES is out of bounds
//  V_RES   480  visible rows; y >= V_RES is out of bounds
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   pixel present on in_* this cycle
//  in_x       in   10  pixel column
//  in_y       in   9   pixel row
//  in_r/g/b   in   8   colour channels
//  in_ready   out  1   advisory: FIFO not full (drawer may ignore)
//  fb_valid   out  1   write request valid
//  fb_ready   in   1   framebuffer accepts the write this cycle
//  fb_addr    out  19  in_y*H_RES + in_x
//  fb_data    out  24  {r, g, b}
//  count      out  $clog2(DEPTH)+1  entries held in FIFO (excludes output register)
//  overflow   out  1   sticky: an in-bounds pixel was dropped because storage was full
//  oob_drops  out  16  saturating count of out-of-bounds pixels discarded
// BEHAVIOUR
//  - Single clock domain; async reset_n. Reset values: fb_valid=0, fb_addr=0, fb_data=0,
//    count=0, overflow=0, oob_drops=0, in_ready=1. FIFO pointers cleared.
//  - Accept: in_valid=1. If in_x>=H_RES or in_y>=V_RES, discard and increment oob_drops
//    (saturates at 16'hFFFF). Otherwise address is computed at enqueue and {addr, rgb} is pushed.
//  - Push while full (count==DEPTH and output register occupied): entry dropped, overflow<=1.
//    overflow clears only on reset.
//  - Output register is a 2-state FSM:
//    - EMPTY: fb_valid=0. Moves to HOLD when FIFO non-empty; pops head into fb_addr/fb_data.
//    - HOLD: fb_valid=1; fb_addr/fb_data stable until fb_ready=1.
//      - On fb_ready=1 with FIFO non-empty: pop next entry, stay HOLD (back-to-back, 1 write/cycle).
//      - On fb_ready=1 with FIFO empty: go to EMPTY.
//  - Latency: pixel accepted at cycle N into an empty buffer gives fb_valid=1 at N+2
//    (N+1 FIFO write, N+2 output load). Total capacity is DEPTH+1.
//  - Simultaneous push and pop on full FIFO: pop happens first, push succeeds, count unchanged,
//    no overflow.
//  - Push and pop same cycle, count==0, output empty: entry goes through FIFO (no bypass).
//  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  - in_ready = (count < DEPTH).
//  - fb_valid never deasserts without fb_ready (no request withdrawal).
//  - reset_n low mid-transfer: all state cleared immediately; pending writes lost.
// CONFIGURATION
//  PIX_DEDUP_EN defined:
//   - An in-bounds pixel identical (addr and rgb) to the most recently enqueued pixel is
//     discarded; it is not counted as overflow or oob.
//   - The last-enqueued register is cleared by reset, so the first pixel after reset is never
//     dropped.
//  PIX_DEDUP_EN undefined: every in-bounds pixel is enqueued; no comparison logic.
// TESTING
//  1. Assert reset_n=0 mid-stream, release -> fb_valid=0, count=0, overflow=0, oob_drops=0,
//     in_ready=1.
//  2. fb_ready=1; one pixel x=3 y=2 rgb=FF/00/80 -> two cycles later fb_valid=1,
//     fb_addr=1283, fb_data=24'hFF0080, for exactly one cycle.
//  3. fb_ready=0, DEPTH=8; push 10 distinct pixels
//     -> count=8, fb_valid=1 holding pixel 0, overflow=1, in_ready=0.
//     Then fb_ready=1 -> pixels 0..8 emitted in order on 9 consecutive cycles; pixel 9 never appears.
//  4. Push x=640 y=0, then x=0 y=480 -> oob_drops=2, fb_valid stays 0.
//     Push 70000 OOB pixels -> oob_drops=16'hFFFF.
//  5. fb_ready toggling 1/0 each cycle while pushing 1 pixel/cycle for 6 pixels -> each fb_addr
//     held stable across stall cycles; all 6 emitted in order; no overflow.
//  6. With PIX_DEDUP_EN: push x=5 y=5 rgb=000000 twice, then rgb=FFFFFF -> exactly 2 writes emitted.
//     Without PIX_DEDUP_EN -> 3 writes emitted.

Source files
------------

// File: rtl/pixel_write_buffer.sv
// Bounds-checked pixel write FIFO feeding a valid/ready framebuffer port.
// Optional PIX_DEDUP_EN drops a pixel identical to the last one enqueued.
module pixel_write_buffer #(
    parameter int DEPTH = 8,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [9:0]               in_x,
    input  logic [8:0]               in_y,
    input  logic [7:0]               in_r,
    input  logic [7:0]               in_g,
    input  logic [7:0]               in_b,
    output logic                     in_ready,
    output logic                     fb_valid,
    input  logic                     fb_ready,
    output logic [18:0]              fb_addr,
    output logic [23:0]              fb_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              oob_drops
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 43;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [10:0] LIM_X = 11'(H_RES);
    localparam logic [10:0] LIM_Y = 11'(V_RES);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic [18:0]   r_addr;
    logic [23:0]   r_data;
    logic          r_ovf;
    logic [15:0]   r_oob;

    logic          w_inb;
    logic [18:0]   w_addr;
    logic [EW-1:0] w_entry;
    logic          w_dup;
    logic          w_req;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_oob;

    assign w_inb   = ({1'b0, in_x} < LIM_X) && ({2'b0, in_y} < LIM_Y);
    assign w_addr  = 19'(in_y) * 19'(H_RES) + 19'(in_x);
    assign w_entry = {w_addr, in_r, in_g, in_b};
    assign w_oob   = in_valid & ~w_inb;

`ifdef PIX_DEDUP_EN
    logic          r_last_vld;
    logic [EW-1:0] r_last;

    assign w_dup = r_last_vld && (r_last == w_entry);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_vld <= 1'b0;
            r_last     <= '0;
        end else if (w_push) begin
            r_last_vld <= 1'b1;
            r_last     <= w_entry;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_req  = in_valid & w_inb & ~w_dup;
    assign w_full = (r_count == FULL_CNT);
    // The output register drains first, so a full FIFO can still take a push.
    assign w_pop  = (r_count != '0) & ((r_state == S_EMPTY) | fb_ready);
    assign w_push = w_req & (~w_full | w_pop);
    assign w_drop = w_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_oob   <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop) r_ovf <= 1'b1;
            if (w_oob && r_oob != 16'hFFFF) r_oob <= r_oob + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_pop) begin
                r_addr <= r_mem[r_rptr][42:24];
                r_data <= r_mem[r_rptr][23:0];
            end
            unique case (r_state)
                S_EMPTY: if (w_pop) r_state <= S_HOLD;
                S_HOLD:  if (fb_ready && !w_pop) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign in_ready  = (r_count < FULL_CNT);
    assign fb_valid  = (r_state == S_HOLD);
    assign fb_addr   = r_addr;
    assign fb_data   = r_data;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign oob_drops = r_oob;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer; honours PIX_DEDUP_EN.
module tb_pixel_write_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_ready;
    logic        fb_valid;
    logic        fb_ready;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] oob_drops;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [42:0] q[$];
    logic        stall = 1'b0;
    logic [18:0] pa;
    logic [23:0] pd;

    always #5 clk = ~clk;

    pixel_write_buffer dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_ready(in_ready), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_addr(fb_addr), .fb_data(fb_data), .count(count),
        .overflow(overflow), .oob_drops(oob_drops)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(int x, int y, int r, int g, int b, bit acc);
        int a;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_x = 10'(x); in_y = 9'(y);
        in_r = 8'(r);  in_g = 8'(g);  in_b = 8'(b);
        a = y * 640 + x;
        if (acc) q.push_back({19'(a), 8'(r), 8'(g), 8'(b)});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        #1 reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(fb_valid), 64'd1);
                chk("hold_addr", 64'(fb_addr), 64'(pa));
                chk("hold_data", 64'(fb_data), 64'(pd));
            end
            if (fb_valid && fb_ready) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    chk("sb_nonempty", 64'(q.size()), 64'd1);
                end else begin
                    logic [42:0] e;
                    e = q.pop_front();
                    chk("wr_addr", 64'(fb_addr), 64'(e[42:24]));
                    chk("wr_data", 64'(fb_data), 64'(e[23:0]));
                end
            end
            stall = fb_valid && !fb_ready;
            pa = fb_addr;
            pd = fb_data;
        end
    end

    initial begin
        int w0;
        reset_n = 1'b0; in_valid = 1'b0; fb_ready = 1'b0;
        in_x = '0; in_y = '0; in_r = '0; in_g = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset mid-stream
        send(700, 0, 1, 2, 3, 0);
        for (int i = 0; i < 3; i++) send(i, 1, i, i, i, 1);
        idle();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(fb_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        repeat (2) @(posedge clk);
        q.delete();
        #1 reset_n = 1'b1;
        #1;
        chk("rst_valid", 64'(fb_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_oob", 64'(oob_drops), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_addr", 64'(fb_addr), 64'd0);
        chk("rst_data", 64'(fb_data), 64'd0);

        // single pixel latency
        fb_ready = 1'b1;
        send(3, 2, 8'hFF, 8'h00, 8'h80, 1);
        idle();
        chk("lat_n1", 64'(fb_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_n2", 64'(fb_valid), 64'd1);
        chk("lat_addr", 64'(fb_addr), 64'd1283);
        chk("lat_data", 64'(fb_data), 64'hFF0080);
        @(posedge clk); #1;
        chk("lat_n3", 64'(fb_valid), 64'd0);
        send(639, 479, 1, 2, 3, 1);
        send(639, 480, 4, 5, 6, 0);
        send(640, 479, 7, 8, 9, 0);
        idle();
        repeat (4) @(posedge clk); #1;
        chk("edge_oob", 64'(oob_drops), 64'd2);
        chk("edge_sb", 64'(q.size()), 64'd0);

        // fill and overflow
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(i * 10, i, i, i + 1, i + 2, i < 9);
        idle();
        chk("full_count", 64'(count), 64'd8);
        chk("full_valid", 64'(fb_valid), 64'd1);
        chk("full_addr", 64'(fb_addr), 64'd0);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_ready", 64'(in_ready), 64'd0);
        fb_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b2b_valid", 64'(fb_valid), 64'd1);
        end
        @(negedge clk);
        chk("drain_valid", 64'(fb_valid), 64'd0);
        chk("drain_sb", 64'(q.size()), 64'd0);

        // out of bounds
        do_reset();
        fb_ready = 1'b1;
        send(640, 0, 1, 1, 1, 0);
        send(0, 480, 1, 1, 1, 0);
        idle();
        repeat (3) @(posedge clk); #1;
        chk("oob_two", 64'(oob_drops), 64'd2);
        chk("oob_valid", 64'(fb_valid), 64'd0);
        chk("oob_count", 64'(count), 64'd0);
        for (int i = 0; i < 70000; i++) begin
            if (i[0]) send(0, $urandom_range(480, 511), 0, 0, 0, 0);
            else      send($urandom_range(640, 1023), 0, 0, 0, 0, 0);
        end
        idle();
        #1;
        chk("oob_sat", 64'(oob_drops), 64'hFFFF);
        chk("oob_ovf", 64'(overflow), 64'd0);

        // toggling backpressure
        do_reset();
        fb_ready = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            send(100 + i, 50 + i, 8'h10 * i, 8'hA5, i, 1);
            fb_ready = ~fb_ready;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            fb_ready = ~fb_ready;
        end
        fb_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("tog_writes", 64'(wr_cnt - w0), 64'd6);
        chk("tog_sb", 64'(q.size()), 64'd0);
        chk("tog_ovf", 64'(overflow), 64'd0);

        // duplicate pixels
        do_reset();
        fb_ready = 1'b1;
        w0 = wr_cnt;
        send(5, 5, 0, 0, 0, 1);
`ifdef PIX_DEDUP_EN
        send(5, 5, 0, 0, 0, 0);
`else
        send(5, 5, 0, 0, 0, 1);
`endif
        send(5, 5, 8'hFF, 8'hFF, 8'hFF, 1);
        idle();
        repeat (6) @(posedge clk); #1;
`ifdef PIX_DEDUP_EN
        chk("dup_writes", 64'(wr_cnt - w0), 64'd2);
`else
        chk("dup_writes", 64'(wr_cnt - w0), 64'd3);
`endif
        chk("dup_sb", 64'(q.size()), 64'd0);
        chk("dup_oob", 64'(oob_drops), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
